// File: rtl/mem_arbiter_if.sv
// Bus bundle for the memory arbiter: CPU request port, host request port and memory macro side.
// The arbiter uses the slave modport. Requesters and the memory model use the master modport.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          hst_req;
  logic          hst_we;
  logic [AW-1:0] hst_addr;
  logic [DW-1:0] hst_wdata;
  logic          hst_gnt;
  logic          hst_rvalid;
  logic [DW-1:0] hst_rdata;

  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  hst_req, hst_we, hst_addr, hst_wdata,
    output hst_gnt, hst_rvalid, hst_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output hst_req, hst_we, hst_addr, hst_wdata,
    input  hst_gnt, hst_rvalid, hst_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and a host loader port.
// Owner-based arbitration with a round-robin tie break and a hold limit under contention.
module mem_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.slave        bus,
  output logic [1:0]          dbg_state
);

  // Handshake: a port raises x_req and holds we/addr/wdata stable. Every cycle in which
  // x_req and x_gnt are both high is exactly one transfer. A read returns x_rvalid one cycle later.

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_HST = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          last_hst;
  logic          cpu_rv_q;
  logic          hst_rv_q;
  logic          cpu_gnt;
  logic          hst_gnt;

  assign cpu_gnt = (state == OWN_CPU) & bus.cpu_req;
  assign hst_gnt = (state == OWN_HST) & bus.hst_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req && bus.hst_req) state_nxt = last_hst ? OWN_CPU : OWN_HST;
        else if (bus.cpu_req)           state_nxt = OWN_CPU;
        else if (bus.hst_req)           state_nxt = OWN_HST;
      end
      OWN_CPU: begin
        if (!bus.cpu_req)
          state_nxt = bus.hst_req ? OWN_HST : IDLE;
        else if (hold_cnt == HOLD_LAST && cpu_gnt && bus.hst_req)
          state_nxt = OWN_HST;
      end
      OWN_HST: begin
        if (!bus.hst_req)
          state_nxt = bus.cpu_req ? OWN_CPU : IDLE;
        else if (hold_cnt == HOLD_LAST && hst_gnt && bus.cpu_req)
          state_nxt = OWN_CPU;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last_hst <= 1'b1;
      cpu_rv_q <= 1'b0;
      hst_rv_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        hold_cnt <= '0;
      else if ((cpu_gnt || hst_gnt) && hold_cnt != HOLD_LAST)
        hold_cnt <= hold_cnt + HW'(1);
      if (state_nxt != state && state_nxt == OWN_CPU) last_hst <= 1'b0;
      if (state_nxt != state && state_nxt == OWN_HST) last_hst <= 1'b1;
      cpu_rv_q <= cpu_gnt & ~bus.cpu_we;
      hst_rv_q <= hst_gnt & ~bus.hst_we;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.hst_gnt    = hst_gnt;
  assign bus.cpu_rvalid = cpu_rv_q;
  assign bus.hst_rvalid = hst_rv_q;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.hst_rdata  = bus.mem_rdata;

  assign bus.mem_rd = (cpu_gnt & ~bus.cpu_we) | (hst_gnt & ~bus.hst_we);
  assign bus.mem_wr = (cpu_gnt &  bus.cpu_we) | (hst_gnt &  bus.hst_we);

  // Address/data follow the CPU unless the host holds a grant; forced to zero while in reset.
  assign bus.mem_addr  = !rst_n ? '0 : (hst_gnt ? bus.hst_addr  : bus.cpu_addr);
  assign bus.mem_wdata = !rst_n ? '0 : (hst_gnt ? bus.hst_wdata : bus.cpu_wdata);

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus hand sequences for
// round-robin/hold limit, early release and reset during an outstanding read.
module tb_mem_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CPU  = 2'd1;
  localparam logic [1:0] S_HST  = 2'd2;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;

  mem_arbiter_if #(.AW(5), .DW(8)) bus ();

  mem_arbiter #(.AW(5), .DW(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory macro model: write at the edge, registered read data
  logic [7:0] mem_model [32];
  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 8'h10 + 8'(i);
  end
  always @(posedge clk) begin
    if (bus.mem_wr) mem_model[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  typedef struct {
    logic       cr, cw;
    logic [4:0] ca;
    logic [7:0] cd;
    logic       hr, hw;
    logic [4:0] ha;
    logic [7:0] hd;
    logic [1:0] e_st;
    logic       e_cg, e_hg, e_crv, e_hrv, e_rd, e_wr;
    logic [4:0] e_addr;
    logic [7:0] e_wdata;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [4:0] ca, input logic [7:0] cd,
    input logic hr, input logic hw, input logic [4:0] ha, input logic [7:0] hd,
    input logic [1:0] st, input logic cg, input logic hg, input logic crv, input logic hrv,
    input logic rd, input logic wr, input logic [4:0] ad, input logic [7:0] wd,
    input logic [7:0] rdat);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd;
    v.e_st = st; v.e_cg = cg; v.e_hg = hg; v.e_crv = crv; v.e_hrv = hrv;
    v.e_rd = rd; v.e_wr = wr; v.e_addr = ad; v.e_wdata = wd; v.e_rdata = rdat;
    return v;
  endfunction

  // scoreboard check
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_idle();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.hst_req = 0; bus.hst_we = 0; bus.hst_addr = 0; bus.hst_wdata = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    bus.cpu_req = v.cr; bus.cpu_we = v.cw; bus.cpu_addr = v.ca; bus.cpu_wdata = v.cd;
    bus.hst_req = v.hr; bus.hst_we = v.hw; bus.hst_addr = v.ha; bus.hst_wdata = v.hd;
    @(negedge clk);
    check($sformatf("v%0d state", idx), 32'(dbg_state), 32'(v.e_st));
    check($sformatf("v%0d cpu_gnt", idx), 32'(bus.cpu_gnt), 32'(v.e_cg));
    check($sformatf("v%0d hst_gnt", idx), 32'(bus.hst_gnt), 32'(v.e_hg));
    check($sformatf("v%0d cpu_rvalid", idx), 32'(bus.cpu_rvalid), 32'(v.e_crv));
    check($sformatf("v%0d hst_rvalid", idx), 32'(bus.hst_rvalid), 32'(v.e_hrv));
    check($sformatf("v%0d mem_rd", idx), 32'(bus.mem_rd), 32'(v.e_rd));
    check($sformatf("v%0d mem_wr", idx), 32'(bus.mem_wr), 32'(v.e_wr));
    check($sformatf("v%0d mem_addr", idx), 32'(bus.mem_addr), 32'(v.e_addr));
    check($sformatf("v%0d mem_wdata", idx), 32'(bus.mem_wdata), 32'(v.e_wdata));
    if (v.e_crv) check($sformatf("v%0d cpu_rdata", idx), 32'(bus.cpu_rdata), 32'(v.e_rdata));
    if (v.e_hrv) check($sformatf("v%0d hst_rdata", idx), 32'(bus.hst_rdata), 32'(v.e_rdata));
    next_cycle();
  endtask

  initial begin
    logic       exp_c, exp_h, prev_c, prev_h;
    logic [7:0] exp_q [$];
    checks = 0;
    errors = 0;

    // CPU-only reads of 0..7, then release
    vecs.push_back(mk(1,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,5'(i),8'h00, 0,0,5'd0,8'h00, S_CPU, 1,0,(i > 0),0, 1,0,
                        5'(i),8'h00, 8'h10 + 8'(i) - 8'h01));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_CPU,  0,0,1,0, 0,0, 5'd0,8'h00, 8'h17));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));
    // host writes 0x5A to addr 3 and releases; CPU reads it back
    vecs.push_back(mk(0,0,5'd0,8'h00, 1,1,5'd3,8'h5A, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));
    vecs.push_back(mk(0,0,5'd0,8'h00, 1,1,5'd3,8'h5A, S_HST,  0,1,0,0, 0,1, 5'd3,8'h5A, 8'h00));
    vecs.push_back(mk(1,0,5'd3,8'h00, 0,0,5'd0,8'h00, S_HST,  0,0,0,0, 0,0, 5'd3,8'h00, 8'h00));
    vecs.push_back(mk(1,0,5'd3,8'h00, 0,0,5'd0,8'h00, S_CPU,  1,0,0,0, 1,0, 5'd3,8'h00, 8'h00));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_CPU,  0,0,1,0, 0,0, 5'd0,8'h00, 8'h5A));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));
    // host read of addr 3: only hst_rvalid rises
    vecs.push_back(mk(0,0,5'd0,8'h00, 1,0,5'd3,8'h00, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));
    vecs.push_back(mk(0,0,5'd0,8'h00, 1,0,5'd3,8'h00, S_HST,  0,1,0,0, 1,0, 5'd3,8'h00, 8'h00));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_HST,  0,0,0,1, 0,0, 5'd0,8'h00, 8'h5A));
    vecs.push_back(mk(0,0,5'd0,8'h00, 0,0,5'd0,8'h00, S_IDLE, 0,0,0,0, 0,0, 5'd0,8'h00, 8'h00));

    // reset state
    drive_idle();
    bus.cpu_addr = 5'd9;
    bus.cpu_wdata = 8'hC3;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    check("rst gnt", 32'({bus.cpu_gnt, bus.hst_gnt}), 32'd0);
    check("rst rvalid", 32'({bus.cpu_rvalid, bus.hst_rvalid}), 32'd0);
    check("rst strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    do_reset();

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // simultaneous requests from reset: CPU first, 4/4 alternation, no bubbles
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 5'd1;
    bus.hst_req = 1; bus.hst_addr = 5'd20;
    prev_c = 0; prev_h = 0;
    for (int c = 0; c <= 16; c++) begin
      exp_c = (c > 0) && (((c - 1) / 4) % 2 == 0);
      exp_h = (c > 0) && !exp_c;
      @(negedge clk);
      check($sformatf("rr c%0d cpu_gnt", c), 32'(bus.cpu_gnt), 32'(exp_c));
      check($sformatf("rr c%0d hst_gnt", c), 32'(bus.hst_gnt), 32'(exp_h));
      check($sformatf("rr c%0d cpu_rvalid", c), 32'(bus.cpu_rvalid), 32'(prev_c));
      check($sformatf("rr c%0d hst_rvalid", c), 32'(bus.hst_rvalid), 32'(prev_h));
      if (prev_c || prev_h) begin
        check($sformatf("rr c%0d rdata", c), 32'(bus.cpu_rdata), 32'(exp_q.pop_front()));
      end
      if (exp_c) exp_q.push_back(8'h11);
      if (exp_h) exp_q.push_back(8'h24);
      prev_c = exp_c; prev_h = exp_h;
      next_cycle();
    end

    // CPU releases after 2 transfers while host waits; host then gets a full 4
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 5'd2;
    bus.hst_req = 1; bus.hst_addr = 5'd21;
    @(negedge clk);
    check("rel c0 state", 32'(dbg_state), 32'(S_IDLE));
    next_cycle();
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check($sformatf("rel c%0d cpu_gnt", c), 32'(bus.cpu_gnt), 32'd1);
      next_cycle();
    end
    bus.cpu_req = 0;
    @(negedge clk);
    check("rel c3 state", 32'(dbg_state), 32'(S_CPU));
    check("rel c3 gnt", 32'({bus.cpu_gnt, bus.hst_gnt}), 32'd0);
    next_cycle();
    bus.cpu_req = 1;
    for (int c = 4; c <= 8; c++) begin
      exp_h = (c < 8);
      @(negedge clk);
      check($sformatf("rel c%0d hst_gnt", c), 32'(bus.hst_gnt), 32'(exp_h));
      check($sformatf("rel c%0d cpu_gnt", c), 32'(bus.cpu_gnt), 32'(!exp_h));
      check($sformatf("rel c%0d state", c), 32'(dbg_state), exp_h ? 32'(S_HST) : 32'(S_CPU));
      next_cycle();
    end

    // reset asserted the cycle after a granted host read
    do_reset();
    bus.hst_req = 1; bus.hst_addr = 5'd5;
    next_cycle();
    @(negedge clk);
    check("rst5 hst_gnt", 32'(bus.hst_gnt), 32'd1);
    check("rst5 mem_rd", 32'(bus.mem_rd), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.cpu_addr = 5'd9;
    bus.cpu_wdata = 8'hAA;
    #1;
    check("rst5 hst_rvalid async", 32'(bus.hst_rvalid), 32'd0);
    check("rst5 state async", 32'(dbg_state), 32'(S_IDLE));
    check("rst5 gnt async", 32'({bus.cpu_gnt, bus.hst_gnt}), 32'd0);
    check("rst5 mem_addr async", 32'(bus.mem_addr), 32'd0);
    check("rst5 mem_wdata async", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    check("rst5 hst_rvalid held", 32'(bus.hst_rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.cpu_req = 1;
    @(negedge clk);
    check("rst5 post state", 32'(dbg_state), 32'(S_IDLE));
    check("rst5 post hst_rvalid", 32'(bus.hst_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rst5 tie cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("rst5 tie hst_gnt", 32'(bus.hst_gnt), 32'd0);
    next_cycle();
    drive_idle();
    next_cycle();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
